uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 3_000_000, meaning the line rate in bit/s.
REQ-003 The module SHALL have parameter NUM_DATA_BITS, default 8, meaning data bits per frame; legal range 5-9.
REQ-004 The module SHALL have parameter PARITY_ON, default 1, where 0 means no parity bit and 1 means a parity bit is sent.
REQ-005 The module SHALL have parameter PARITY_EO, default 1, where 0 means even parity and 1 means odd parity.
REQ-006 The module SHALL have parameter NUM_STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-007 The module SHALL have port i_clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-008 The module SHALL have port i_rst, input, width 1, an asynchronous active-high reset.
REQ-009 The module SHALL have port i_tx_data, input, width NUM_DATA_BITS, the byte to transmit.
REQ-010 The module SHALL have port i_tx_valid, input, width 1, asserted when i_tx_data is valid.
REQ-011 The module SHALL have port o_tx_ready, output, width 1, asserted when the block can accept a byte.
REQ-012 The module SHALL have port o_tx, output, width 1, the serial line; it idles high.
REQ-013 The module SHALL have port o_tx_busy, output, width 1, high while a frame is on the line.
REQ-014 The module SHALL have port o_tx_done, output, width 1, a one-cycle pulse at frame completion.

Function
REQ-015 BIT_CLKS SHALL equal CLK_FREQ/BAUD_RATE rounded to the nearest integer; elaboration SHALL fail if BIT_CLKS < 2 or if any parameter is illegal.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE, o_tx SHALL be 1, o_tx_ready 1 and o_tx_busy 0.
REQ-018 A handshake SHALL occur on a rising edge where i_tx_valid=1 and o_tx_ready=1; at that edge i_tx_data is latched into an internal shift register and the FSM moves to START.
REQ-019 Changes on i_tx_data after the handshake SHALL NOT affect the frame in progress.
REQ-020 While outside IDLE, o_tx_ready SHALL be 0 and o_tx_busy SHALL be 1, and i_tx_valid SHALL be ignored.
REQ-021 o_tx SHALL be registered: it goes low in the first cycle after the handshake edge.
REQ-022 Each bit SHALL be held for exactly BIT_CLKS cycles, counted by a bit-timer that reloads at every bit boundary.
REQ-023 START SHALL drive 0 for one bit time.
REQ-024 DATA SHALL drive data LSB first, one bit per bit time, for NUM_DATA_BITS bits, tracked by a bit index counter.
REQ-025 PARITY, entered only if PARITY_ON=1, SHALL drive ^data for even parity or ~^data for odd parity, computed over the latched byte.
REQ-026 If PARITY_ON=0, DATA SHALL transition directly to STOP.
REQ-027 STOP SHALL drive 1 for NUM_STOP_BITS bit times and then return to IDLE.
REQ-028 A frame SHALL last exactly (1 + NUM_DATA_BITS + PARITY_ON + NUM_STOP_BITS) x BIT_CLKS cycles of o_tx activity.
REQ-029 o_tx_done SHALL pulse for exactly the first cycle in IDLE after STOP; o_tx_ready is 1 in that same cycle.
REQ-030 Back-to-back frames: if i_tx_valid is held high, the next handshake SHALL occur in the o_tx_done cycle, and the next start bit SHALL begin one cycle later, with no further idle gap beyond that.
REQ-031 An illegal or unknown state SHALL recover to IDLE on the next clock edge, with o_tx=1.

Reset
REQ-032 On i_rst=1, the module SHALL immediately (asynchronously) force: state=IDLE, o_tx=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0, and the bit-timer, bit index and shift register to 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame, leaving the line high; no o_tx_done pulse SHALL be generated for the aborted frame.
REQ-034 The first handshake SHALL be possible on the first rising edge after i_rst deasserts.

Verification (CLK_FREQ=100_000_000, BAUD_RATE=10_000_000, so BIT_CLKS=10)
REQ-035 Single frame, 8O1: send 0xA5 -> o_tx = 0, then 1,0,1,0,0,1,0,1, then parity 1, then stop 1, each bit held 10 cycles; 110 cycles busy; o_tx_done pulses once.
REQ-036 Even parity with PARITY_EO=0: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
REQ-037 PARITY_ON=0, NUM_STOP_BITS=2, NUM_DATA_BITS=7: send 0x55 -> 10-bit frame of 100 cycles; stop held high for 20 cycles.
REQ-038 Back-to-back: hold i_tx_valid with 0x00 then 0xFF -> second start bit begins exactly 1 cycle after o_tx_done; o_tx_ready stays 0 throughout each frame.
REQ-039 Reset mid-frame: assert i_rst during data bit 3 -> o_tx goes to 1 in the same cycle with no edge wait, o_tx_busy=0, no o_tx_done pulse; a new byte is accepted on the first edge after release.
REQ-040 Loopback: connect o_tx to uart_rx configured with the same parameters and send 256 random bytes -> all bytes are received with o_rx_byte_valid=1 and o_rx_err=0.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Accepts a word on a valid/ready handshake; every output is registered.
module uart_tx #(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned BAUD_RATE     = 3_000_000,
    parameter int unsigned NUM_DATA_BITS = 8,
    parameter int unsigned PARITY_ON     = 1,
    parameter int unsigned PARITY_EO     = 1,
    parameter int unsigned NUM_STOP_BITS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_DATA_BITS-1:0] i_tx_data,
    input  logic                     i_tx_valid,
    output logic                     o_tx_ready,
    output logic                     o_tx,
    output logic                     o_tx_busy,
    output logic                     o_tx_done
);

    localparam int unsigned BIT_CLKS = (BAUD_RATE == 0) ? 0 : (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned TIMER_W  = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam int unsigned IDX_W    = 4;

    if (BIT_CLKS < 2 || NUM_DATA_BITS < 5 || NUM_DATA_BITS > 9 || PARITY_ON > 1 ||
        PARITY_EO > 1 || NUM_STOP_BITS < 1 || NUM_STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic                     tx_q, tx_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     bit_end;

    assign bit_end = (timer_q == '0);

    // Next-state and next-output logic; o_tx is set to the value of the bit being entered.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE) begin
            timer_d = bit_end ? TIMER_W'(BIT_CLKS - 1) : timer_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (i_tx_valid && ready_q) begin
                    state_d   = S_START;
                    shift_d   = i_tx_data;
                    parity_d  = (PARITY_EO != 0) ? ~^i_tx_data : ^i_tx_data;
                    timer_d   = TIMER_W'(BIT_CLKS - 1);
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(NUM_DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (PARITY_ON != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(NUM_STOP_BITS - 1)) begin
                        state_d   = S_IDLE;
                        timer_d   = '0;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                timer_d   = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_tx       = tx_q;
    assign o_tx_ready = ready_q;
    assign o_tx_busy  = busy_q;
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three configurations (8O1, 8E1, 7N2) at 10 clocks per bit.
module tb_uart_tx;

    localparam int unsigned BIT = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       valid_a, valid_e, valid_c;
    logic [7:0] data_a, data_e;
    logic [6:0] data_c;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_e, tx_e, busy_e, done_e;
    logic       ready_c, tx_c, busy_c, done_c;

    uart_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .NUM_DATA_BITS(8),
              .PARITY_ON(1), .PARITY_EO(1), .NUM_STOP_BITS(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_tx_data(data_a), .i_tx_valid(valid_a),
        .o_tx_ready(ready_a), .o_tx(tx_a), .o_tx_busy(busy_a), .o_tx_done(done_a));

    uart_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .NUM_DATA_BITS(8),
              .PARITY_ON(1), .PARITY_EO(0), .NUM_STOP_BITS(1)) u_e (
        .i_clk(clk), .i_rst(rst), .i_tx_data(data_e), .i_tx_valid(valid_e),
        .o_tx_ready(ready_e), .o_tx(tx_e), .o_tx_busy(busy_e), .o_tx_done(done_e));

    uart_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .NUM_DATA_BITS(7),
              .PARITY_ON(0), .PARITY_EO(0), .NUM_STOP_BITS(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_tx_data(data_c), .i_tx_valid(valid_c),
        .o_tx_ready(ready_c), .o_tx(tx_c), .o_tx_busy(busy_c), .o_tx_done(done_c));

    int   sel;
    logic tx_m, ready_m, busy_m, done_m;

    always_comb begin
        case (sel)
            1:       begin tx_m = tx_e; ready_m = ready_e; busy_m = busy_e; done_m = done_e; end
            2:       begin tx_m = tx_c; ready_m = ready_c; busy_m = busy_c; done_m = done_c; end
            default: begin tx_m = tx_a; ready_m = ready_a; busy_m = busy_a; done_m = done_a; end
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            1:       begin valid_e = v; data_e = d; end
            2:       begin valid_c = v; data_c = d[6:0]; end
            default: begin valid_a = v; data_a = d; end
        endcase
    endtask

    // Handshake one word, then sample every cycle of the frame; exp lists line bits in send order.
    task automatic send(input string name, input int s, input logic [7:0] d, input logic [7:0] d_after,
                        input logic keep, input int nbits, input logic [15:0] exp);
        logic [15:0] got;
        int unstable, busy_cnt, ready_hi, done_hi;
        sel = s;
        #1;
        check({name, "_ready_pre"}, ready_m, 1);
        drive(s, 1'b1, d);
        tick();
        drive(s, keep, d_after);
        got = '0; unstable = 0; busy_cnt = 0; ready_hi = 0; done_hi = 0;
        for (int c = 0; c < nbits * BIT; c++) begin
            if (c % BIT == 0) got[c / BIT] = tx_m;
            else if (tx_m !== got[c / BIT]) unstable++;
            if (busy_m === 1'b1)  busy_cnt++;
            if (ready_m !== 1'b0) ready_hi++;
            if (done_m !== 1'b0)  done_hi++;
            tick();
        end
        check({name, "_frame"}, got, exp);
        check({name, "_bit_hold"}, unstable, 0);
        check({name, "_busy_cycles"}, busy_cnt, nbits * BIT);
        check({name, "_ready_in_frame"}, ready_hi, 0);
        check({name, "_done_in_frame"}, done_hi, 0);
        check({name, "_done_pulse"}, done_m, 1);
        check({name, "_ready_post"}, ready_m, 1);
        check({name, "_busy_post"}, busy_m, 0);
        check({name, "_tx_post"}, tx_m, 1);
        if (!keep) begin
            tick();
            check({name, "_done_one_cycle"}, done_m, 0);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int done_seen;
        sel = 0;
        rst = 1'b1;
        valid_a = 1'b0; valid_e = 1'b0; valid_c = 1'b0;
        data_a = '0; data_e = '0; data_c = '0;

        #2;
        check("rst_tx",    tx_a, 1);
        check("rst_ready", ready_a, 1);
        check("rst_busy",  busy_a, 0);
        check("rst_done",  done_a, 0);
        check("rst_tx_c",  tx_c, 1);
        tick();
        rst = 1'b0;

        send("a5_8o1", 0, 8'hA5, 8'h5A, 1'b0, 11, 16'b00000_1_1_10100101_0);
        send("07_8e1", 1, 8'h07, 8'hF8, 1'b0, 11, 16'b00000_1_1_00000111_0);
        send("03_8e1", 1, 8'h03, 8'hFC, 1'b0, 11, 16'b00000_1_0_00000011_0);
        send("55_7n2", 2, 8'h55, 8'h2A, 1'b0, 10, 16'b000000_1_1_1010101_0);

        send("b2b_00", 0, 8'h00, 8'hFF, 1'b1, 11, 16'b00000_1_1_00000000_0);
        send("b2b_ff", 0, 8'hFF, 8'h00, 1'b0, 11, 16'b00000_1_1_11111111_0);

        // Abort a frame in data bit 3, asynchronously and away from any edge.
        sel = 0;
        drive(0, 1'b1, 8'hA5);
        tick();
        drive(0, 1'b0, 8'h00);
        repeat (42) tick();
        check("abort_pre_tx",   tx_a, 0);
        check("abort_pre_busy", busy_a, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_tx",    tx_a, 1);
        check("abort_busy",  busy_a, 0);
        check("abort_ready", ready_a, 1);
        check("abort_done",  done_a, 0);
        done_seen = 0;
        repeat (3) begin
            tick();
            if (done_a !== 1'b0) done_seen++;
        end
        rst = 1'b0;
        check("abort_no_done", done_seen, 0);
        send("after_rst", 0, 8'h3C, 8'hC3, 1'b0, 11, 16'b00000_1_1_00111100_0);

        for (int i = 0; i < 256; i++) begin
            rd = 8'($urandom);
            send("rand", 0, rd, ~rd, 1'b0, 11, {5'b00000, 1'b1, ~^rd, rd, 1'b0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
